etpu_wb_vmac: RTL and testbench

Parametrised wishbone-slave vector MAC engine; next generation of the educational TPU macro behind the Caravel user-project wrapper.
- Host writes per-lane weights and pushes packed activation vectors into a FIFO, then starts a run.
- An FSM pops COUNT vectors and accumulates signed products per lane with saturation.
- Raises done/irq on completion, mirrors status onto the logic analyser, and gates all outputs with `active`.

---
 rtl/etpu_wb_vmac.sv | 209 ++++++++++++++++++++
 tb/tb_etpu_wb_vmac.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etpu_wb_vmac.sv
// Wishbone vector MAC: per-lane signed weights times FIFO-fed activations, saturating accumulate.
// Latency: ack one cycle after request; RUN pops one vector per cycle, DONE one cycle after last pop.
// Backpressure: RUN stalls on empty FIFO; pushes to a full FIFO are dropped and flagged as overflow.

module etpu_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO still lands when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rptr];

  // pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // storage is only read while occupied, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end
endmodule

module etpu_wb_vmac #(
  parameter int          LANES     = 4,
  parameter int          DW        = 8,
  parameter int          ACCW      = 24,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        active,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] la1_data_out,
  output logic        irq_o
);
  localparam int VW = LANES * DW;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                 state;
  logic                   rst, req, ack, wr, busy, start, clr, push, pop, full, empty;
  logic                   irq_en, done, overflow, sat, unused;
  logic [5:0]             word;
  logic [7:0]             run_count, remaining, fifo_cnt8;
  logic [CW-1:0]          fifo_cnt;
  logic [VW-1:0]          pop_dat;
  logic [31:0]            rdata;
  logic [LANES-1:0]       lane_sat;
  logic signed [DW-1:0]   weight  [LANES];
  logic signed [ACCW-1:0] acc     [LANES];
  logic signed [ACCW-1:0] acc_nxt [LANES];

  assign rst       = wb_rst_i | ~active;
  assign req       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign word      = wbs_adr_i[7:2];
  // side effects happen in the ack cycle, while the master still holds address and data
  assign wr        = ack & wbs_we_i & wbs_cyc_i & wbs_stb_i;
  assign busy      = (state != IDLE);
  assign start     = wr & (word == 6'h00) & wbs_dat_i[0] & ~busy;
  assign clr       = wr & (word == 6'h00) & wbs_dat_i[1] & ~busy;
  assign push      = wr & (word == 6'h10);
  assign pop       = (state == RUN) & ~empty;
  assign fifo_cnt8 = 8'(fifo_cnt);
  assign unused    = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

  etpu_fifo #(.W(VW), .DEPTH(DEPTH)) u_fifo (
    .clk      (wb_clk_i),
    .rst      (rst),
    .push     (push),
    .push_dat (wbs_dat_i[VW-1:0]),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (full),
    .empty    (empty),
    .count    (fifo_cnt)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW:0]   sum;
    assign prod        = (2*DW)'(weight[g]) * (2*DW)'($signed(pop_dat[DW*g +: DW]));
    // one guard bit: overflow shows up as disagreement between the top two bits
    assign sum         = (ACCW+1)'(acc[g]) + (ACCW+1)'(prod);
    assign lane_sat[g] = sum[ACCW] ^ sum[ACCW-1];
    assign acc_nxt[g]  = lane_sat[g] ? (sum[ACCW] ? ACC_MIN : ACC_MAX) : sum[ACCW-1:0];
  end

  // register read mux; unmapped offsets read zero
  always_comb begin
    rdata = '0;
    case (word)
      6'h00:   rdata = {29'b0, irq_en, 2'b0};
      6'h01:   rdata = {16'b0, fifo_cnt8, 2'b0, sat, overflow, empty, full, done, busy};
      6'h02:   rdata = {24'b0, run_count};
      default: begin
        for (int i = 0; i < LANES; i++) begin
          if (int'(word) == 4 + i)  rdata = 32'(weight[i]);
          if (int'(word) == 32 + i) rdata = 32'(acc[i]);
        end
      end
    endcase
  end

  // bus handshake, config registers, sticky flags and the IDLE/RUN/DONE sequencer
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= 1'b0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      sat       <= 1'b0;
      run_count <= '0;
      remaining <= '0;
      for (int i = 0; i < LANES; i++) begin
        weight[i] <= '0;
        acc[i]    <= '0;
      end
    end else begin
      ack <= req & ~ack;
      if (wr && word == 6'h00) irq_en <= wbs_dat_i[2];
      if (wr && word == 6'h02 && !busy) run_count <= wbs_dat_i[7:0];
      for (int i = 0; i < LANES; i++) begin
        if (wr && !busy && int'(word) == 4 + i) weight[i] <= wbs_dat_i[DW-1:0];
        if (clr) acc[i] <= '0;
      end
      // W1C first so that a flag raised in the same cycle wins
      if (wr && word == 6'h01) begin
        if (wbs_dat_i[1]) done     <= 1'b0;
        if (wbs_dat_i[4]) overflow <= 1'b0;
        if (wbs_dat_i[5]) sat      <= 1'b0;
      end
      if (push && full && !pop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            if (run_count != 8'd0) begin
              remaining <= run_count;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pop) begin
            for (int i = 0; i < LANES; i++) acc[i] <= acc_nxt[i];
            if (|lane_sat) sat <= 1'b1;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o    = ack & active;
  assign wbs_dat_o    = (ack && active) ? rdata : 32'd0;
  assign la1_data_out = active ? {acc[0][11:0], fifo_cnt8, remaining, overflow, done, state} : 32'd0;
  assign irq_o        = done & irq_en & active;
endmodule

// File: tb/tb_etpu_wb_vmac.sv
// Bench for etpu_wb_vmac: transaction-level model compared every cycle plus literal register checks.
// Latency: bus tasks expect ack on the cycle after the request.
// Backpressure: every wait is bounded; a missing ack counts as a miscompare.
module tb_etpu_wb_vmac;
  localparam logic [31:0] B = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        wb_rst_i, active, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r, la1;
  logic        ack, irq;

  etpu_wb_vmac #(.LANES(4), .DW(8), .ACCW(16), .DEPTH(8), .BASE_ADDR(32'h3000_0000)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (wb_rst_i),
    .active       (active),
    .wbs_stb_i    (stb),
    .wbs_cyc_i    (cyc),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_dat_i    (dat_w),
    .wbs_adr_i    (adr),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_r),
    .la1_data_out (la1),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;

  // model state: plain integers and a queue standing in for the FIFO
  int          m_w [4];
  int          m_acc [4];
  logic [31:0] m_q [$];
  bit          m_ack, m_irq_en, m_done, m_ovf, m_sat;
  int          m_count, m_rem, m_phase;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int s8(input logic [7:0] x);
    return int'($signed(x));
  endfunction

  function automatic logic [31:0] m_read(input int word);
    if (word == 0) return {29'b0, m_irq_en, 2'b0};
    if (word == 1) return {16'b0, 8'(m_q.size()), 2'b0, m_sat, m_ovf, (m_q.size() == 0),
                           (m_q.size() == 8), m_done, (m_phase != 0)};
    if (word == 2) return 32'(m_count);
    if (word >= 4 && word < 8) return 32'(m_w[word-4]);
    if (word >= 32 && word < 36) return 32'(m_acc[word-32]);
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_la1();
    return {m_acc[0][11:0], 8'(m_q.size()), 8'(m_rem), m_ovf, m_done, 2'(m_phase)};
  endfunction

  task automatic m_reset();
    m_ack = 0; m_irq_en = 0; m_done = 0; m_ovf = 0; m_sat = 0;
    m_count = 0; m_rem = 0; m_phase = 0;
    m_q.delete();
    for (int i = 0; i < 4; i++) begin m_w[i] = 0; m_acc[i] = 0; end
  endtask

  task automatic model_step();
    bit          hit = (adr[31:8] == B[31:8]);
    bit          wr  = m_ack && we && cyc && stb;
    int          word = int'(adr[7:2]);
    bit          bsy = (m_phase != 0);
    bit          pop = (m_phase == 1) && (m_q.size() > 0);
    bit          push = 0;
    bit          start = 0;
    logic [31:0] v;
    int          s;
    m_ack = cyc && stb && hit && !m_ack;
    if (wr) begin
      if (word == 0) begin
        m_irq_en = dat_w[2];
        if (!bsy && dat_w[1]) for (int i = 0; i < 4; i++) m_acc[i] = 0;
        start = !bsy && dat_w[0];
      end else if (word == 1) begin
        if (dat_w[1]) m_done = 0;
        if (dat_w[4]) m_ovf = 0;
        if (dat_w[5]) m_sat = 0;
      end else if (word == 2) begin
        if (!bsy) m_count = int'(dat_w[7:0]);
      end else if (word == 16) begin
        push = 1;
      end else if (word >= 4 && word < 8 && !bsy) begin
        m_w[word-4] = s8(dat_w[7:0]);
      end
    end
    if (pop) begin
      v = m_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        s = m_acc[i] + m_w[i] * s8(v[8*i +: 8]);
        if (s > 32767)  begin s = 32767;  m_sat = 1; end
        if (s < -32768) begin s = -32768; m_sat = 1; end
        m_acc[i] = s;
      end
      m_rem--;
    end
    if (push) begin
      if (m_q.size() < 8) m_q.push_back(dat_w);
      else m_ovf = 1;
    end
    if (m_phase == 0) begin
      if (start) begin
        if (m_count != 0) begin m_rem = m_count; m_phase = 1; end
        else m_done = 1;
      end
    end else if (m_phase == 1) begin
      if (pop && m_rem == 0) m_phase = 2;
    end else begin
      m_done = 1;
      m_phase = 0;
    end
  endtask

  // model advances on the same edge as the DUT
  always @(posedge clk) begin
    if (wb_rst_i || !active) m_reset();
    else model_step();
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", {31'b0, ack}, {31'b0, active & m_ack});
      chk("dat", dat_r, (active && m_ack) ? m_read(int'(adr[7:2])) : 32'd0);
      chk("la1", la1, active ? m_la1() : 32'd0);
      chk("irq", {31'b0, irq}, {31'b0, active & m_done & m_irq_en});
    end
  end

  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output bit got, output int lat);
    cyc = 1; stb = 1; we = w; adr = a; dat_w = d;
    got = 0; rd = 0; lat = -1;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (ack) begin got = 1; rd = dat_r; lat = k; end
      @(posedge clk); #1;
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; bit g; int l;
    bus(1'b1, a, d, r, g, l);
    chk("wr_ack", 32'(g), 32'd1);
  endtask

  task automatic bus_rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r; bit g; int l;
    bus(1'b0, a, 32'd0, r, g, l);
    chk({nm, "_ack"}, 32'(g), 32'd1);
    chk(nm, r, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r; bit g; int l; int nbusy;
    wb_rst_i = 1; active = 1; cyc = 0; stb = 0; we = 0; sel = 4'hF; adr = 0; dat_w = 0;
    repeat (3) @(posedge clk);
    #1 wb_rst_i = 0; chk_en = 1;

    // reset state
    chk("rst_la1", la1, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    bus_rd_chk("rst_status", B + 32'h04, 32'h0000_0008);
    bus_rd_chk("rst_ctrl", B + 32'h00, 32'h0);

    // basic run: W={1,2,3,4}, vectors {1,2,3,4} and {2,2,2,2}
    for (int i = 0; i < 4; i++) bus_wr(B + 32'h10 + 32'(4*i), 32'(i + 1));
    bus_wr(B + 32'h40, 32'h0403_0201);
    bus_wr(B + 32'h40, 32'h0202_0202);
    bus_wr(B + 32'h08, 32'd2);
    bus_wr(B + 32'h00, 32'h5);
    nbusy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (la1[1:0] != 2'd0) nbusy++;
    end
    @(posedge clk); #1;
    chk("busy_cycles", 32'(nbusy), 32'd3);
    bus_rd_chk("run_status", B + 32'h04, 32'h0000_000A);
    chk("irq_set", {31'b0, irq}, 32'd1);
    bus_rd_chk("acc0", B + 32'h80, 32'd3);
    bus_rd_chk("acc1", B + 32'h84, 32'd8);
    bus_rd_chk("acc2", B + 32'h88, 32'd15);
    bus_rd_chk("acc3", B + 32'h8C, 32'd24);
    bus_wr(B + 32'h04, 32'h2);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    bus_rd_chk("w1c_status", B + 32'h04, 32'h0000_0008);

    // overflow: nine pushes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) bus_wr(B + 32'h40, 32'h0101_0101);
    bus_rd_chk("ovf_status", B + 32'h04, 32'h0000_0814);
    bus_wr(B + 32'h04, 32'h10);
    bus_wr(B + 32'h08, 32'd9);
    bus_wr(B + 32'h00, 32'h1);
    bus_wr(B + 32'h40, 32'h0101_0101);
    repeat (14) @(posedge clk); #1;
    bus_rd_chk("drain_status", B + 32'h04, 32'h0000_000A);

    // positive saturation
    bus_wr(B + 32'h04, 32'h32);
    bus_wr(B + 32'h10, 32'd127);
    bus_wr(B + 32'h00, 32'h2);
    bus_wr(B + 32'h08, 32'd255);
    bus_wr(B + 32'h00, 32'h1);
    for (int i = 0; i < 255; i++) bus_wr(B + 32'h40, 32'h0000_007F);
    repeat (4) @(posedge clk); #1;
    bus_rd_chk("sat_pos", B + 32'h80, 32'h0000_7FFF);
    bus_rd_chk("sat_status", B + 32'h04, 32'h0000_002A);

    // negative saturation
    bus_wr(B + 32'h04, 32'h22);
    bus_wr(B + 32'h10, 32'hFFFF_FF80);
    bus_wr(B + 32'h00, 32'h2);
    for (int i = 0; i < 3; i++) bus_wr(B + 32'h40, 32'h0000_007F);
    bus_wr(B + 32'h08, 32'd3);
    bus_wr(B + 32'h00, 32'h1);
    repeat (6) @(posedge clk); #1;
    bus_rd_chk("sat_neg", B + 32'h80, 32'hFFFF_8000);
    bus_rd_chk("sat_neg_status", B + 32'h04, 32'h0000_002A);

    // stall on empty FIFO
    bus_wr(B + 32'h04, 32'h22);
    bus_wr(B + 32'h00, 32'h2);
    bus_wr(B + 32'h08, 32'd3);
    bus_wr(B + 32'h00, 32'h1);
    chk("stall_la1", la1, 32'h0000_0031);
    for (int k = 1; k <= 3; k++) begin
      repeat (5) @(posedge clk); #1;
      bus_wr(B + 32'h40, 32'h0101_0101);
      @(posedge clk); #1;
      chk("stall_rem", {24'b0, la1[11:4]}, 32'(3 - k));
      if (k < 3) chk("stall_done", {31'b0, la1[2]}, 32'd0);
    end
    repeat (3) @(posedge clk); #1;
    bus_rd_chk("stall_status", B + 32'h04, 32'h0000_000A);
    bus_rd_chk("stall_acc0", B + 32'h80, 32'hFFFF_FE80);
    bus_rd_chk("stall_acc1", B + 32'h84, 32'd6);

    // drop active mid-run
    bus_wr(B + 32'h00, 32'h4);
    chk("irq_on", {31'b0, irq}, 32'd1);
    bus_wr(B + 32'h08, 32'd5);
    bus_wr(B + 32'h00, 32'h5);
    @(posedge clk); #1;
    active = 0;
    #1;
    chk("inact_la1", la1, 32'd0);
    chk("inact_irq", {31'b0, irq}, 32'd0);
    chk("inact_ack", {31'b0, ack}, 32'd0);
    chk("inact_dat", dat_r, 32'd0);
    @(posedge clk); #1;
    bus(1'b0, B + 32'h04, 32'd0, r, g, l);
    chk("inact_noack", 32'(g), 32'd0);
    active = 1;
    bus_rd_chk("react_status", B + 32'h04, 32'h0000_0008);
    bus_rd_chk("react_acc0", B + 32'h80, 32'd0);
    bus_rd_chk("react_ctrl", B + 32'h00, 32'd0);

    // address decode and writes ignored while busy
    bus_rd_chk("unmapped", B + 32'hFC, 32'd0);
    bus(1'b0, B + 32'h100, 32'd0, r, g, l);
    chk("outside_noack", 32'(g), 32'd0);
    bus_wr(B + 32'h10, 32'd3);
    bus_wr(B + 32'h08, 32'd2);
    bus_wr(B + 32'h00, 32'h1);
    bus(1'b1, B + 32'h10, 32'd5, r, g, l);
    chk("busy_wr_ack", 32'(g), 32'd1);
    chk("busy_wr_lat", 32'(l), 32'd1);
    bus_wr(B + 32'h40, 32'h0000_0001);
    bus_wr(B + 32'h40, 32'h0000_0001);
    repeat (4) @(posedge clk); #1;
    bus_rd_chk("busy_w0", B + 32'h10, 32'd3);
    bus_rd_chk("busy_acc0", B + 32'h80, 32'd6);
    bus_rd_chk("busy_count", B + 32'h08, 32'd2);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
